// File: rtl/ftrace_pkg.sv
// Shared definitions for the function-trace commit path: jump opcodes,
// link-register indices and the buffered call/return record layout.
package ftrace_pkg;

  localparam logic [6:0] OPC_JAL  = 7'b1101111;
  localparam logic [6:0] OPC_JALR = 7'b1100111;

  localparam logic [4:0] RA = 5'd1;
  localparam logic [4:0] T0 = 5'd5;

  // One traced call/return as handed to the sink.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] nextpc;
    logic [31:0] inst;
    logic [5:0]  rd;
    logic        is_call;
  } ftrace_rec_t;

  // x1 (ra) and x5 (t0) are the RISC-V link registers.
  function automatic logic is_link(input logic [4:0] r);
    return (r == RA) || (r == T0);
  endfunction

endpackage

// File: rtl/ftrace_classify.sv
// Combinational RV32 call/return classifier.
// Ports:
//   inst    - raw instruction word
//   is_call - jal/jalr writing a link register
//   is_ret  - jalr x0, 0(link)
//   rd      - destination register, zero-extended to 6 bits
module ftrace_classify
  import ftrace_pkg::*;
(
  input  logic [31:0] inst,
  output logic        is_call,
  output logic        is_ret,
  output logic [5:0]  rd
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [4:0] rd_f;
  logic [4:0] rs1_f;
  logic       jal_op;
  logic       jalr_op;

  assign opcode  = inst[6:0];
  assign rd_f    = inst[11:7];
  assign funct3  = inst[14:12];
  assign rs1_f   = inst[19:15];

  assign jal_op  = (opcode == OPC_JAL);
  assign jalr_op = (opcode == OPC_JALR) && (funct3 == 3'd0);

  assign is_call = (jal_op || jalr_op) && is_link(rd_f);
  assign is_ret  = jalr_op && (rd_f == 5'd0) && is_link(rs1_f);
  assign rd      = {1'b0, rd_f};

  // Immediate bits play no part in classification.
  logic unused_imm;
  assign unused_imm = &{1'b0, inst[31:20]};

endmodule

// File: rtl/ftrace_commit_queue.sv
// Captures call/return records from the commit stage into a small
// first-word-fall-through FIFO and drains them to the trace sink.
// Ports:
//   clock, reset           - clock, synchronous active-low reset
//   commit_valid/pc/nextpc/inst - retiring instruction
//   commit_ready           - low only when a call/return meets a full FIFO
//   out_valid/out_ready    - sink handshake
//   out_pc/nextpc/inst/rd/is_call - head record
//   call_depth             - saturating nesting depth
//   full                   - FIFO holds DEPTH records
module ftrace_commit_queue
  import ftrace_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned DEPTH_W = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               commit_valid,
  input  logic [31:0]        commit_pc,
  input  logic [31:0]        commit_nextpc,
  input  logic [31:0]        commit_inst,
  output logic               commit_ready,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        out_pc,
  output logic [31:0]        out_nextpc,
  output logic [31:0]        out_inst,
  output logic [5:0]         out_rd,
  output logic               out_is_call,
  output logic [DEPTH_W-1:0] call_depth,
  output logic               full
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic              cls_call;
  logic              cls_ret;
  logic [5:0]        cls_rd;
  logic              is_fn;
  logic              enq;
  logic              deq;

  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  ftrace_rec_t       mem [DEPTH];
  ftrace_rec_t       head;
  ftrace_rec_t       wr_rec;

  ftrace_classify u_classify (
    .inst    (commit_inst),
    .is_call (cls_call),
    .is_ret  (cls_ret),
    .rd      (cls_rd)
  );

  assign is_fn        = cls_call | cls_ret;
  assign full         = (count == CNT_W'(DEPTH));
  // Only registered state gates acceptance; out_ready never reaches here.
  assign commit_ready = !(is_fn && full);
  assign out_valid    = (count != '0);

  // Enqueue is refused while full even if the head drains this cycle.
  assign enq = commit_valid && is_fn && !full;
  assign deq = out_valid && out_ready;

  assign wr_rec = '{pc: commit_pc, nextpc: commit_nextpc, inst: commit_inst,
                    rd: cls_rd, is_call: cls_call};

  // Record storage; contents are don't-care across reset.
  always_ff @(posedge clock) begin
    if (enq) begin
      mem[wr_ptr] <= wr_rec;
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + PTR_W'(1);
      if (deq) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({enq, deq})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Nesting depth follows accepted records only, saturating both ways.
  always_ff @(posedge clock) begin
    if (!reset) begin
      call_depth <= '0;
    end else if (enq) begin
      if (cls_call && (call_depth != '1)) begin
        call_depth <= call_depth + DEPTH_W'(1);
      end else if (cls_ret && (call_depth != '0)) begin
        call_depth <= call_depth - DEPTH_W'(1);
      end
    end
  end

  // First-word fall-through head.
  assign head        = mem[rd_ptr];
  assign out_pc      = head.pc;
  assign out_nextpc  = head.nextpc;
  assign out_inst    = head.inst;
  assign out_rd      = head.rd;
  assign out_is_call = head.is_call;

endmodule

// File: tb/tb_ftrace_commit_queue.sv
module tb_ftrace_commit_queue;

  localparam int unsigned DEPTH   = 4;
  localparam int unsigned DEPTH_W = 8;

  localparam logic [31:0] I_CALL  = 32'h010000EF; // jal ra,16
  localparam logic [31:0] I_RET   = 32'h00008067; // ret
  localparam logic [31:0] I_J     = 32'h0000006F; // j 0
  localparam logic [31:0] I_NOP   = 32'h00000013; // nop
  localparam logic [31:0] I_JALR  = 32'h000780E7; // jalr ra,0(a5)

  logic               clock;
  logic               reset;
  logic               commit_valid;
  logic [31:0]        commit_pc;
  logic [31:0]        commit_nextpc;
  logic [31:0]        commit_inst;
  logic               commit_ready;
  logic               out_valid;
  logic               out_ready;
  logic [31:0]        out_pc;
  logic [31:0]        out_nextpc;
  logic [31:0]        out_inst;
  logic [5:0]         out_rd;
  logic               out_is_call;
  logic [DEPTH_W-1:0] call_depth;
  logic               full;

  int checks;
  int errors;

  ftrace_commit_queue #(.DEPTH(DEPTH), .DEPTH_W(DEPTH_W)) dut (
    .clock         (clock),
    .reset         (reset),
    .commit_valid  (commit_valid),
    .commit_pc     (commit_pc),
    .commit_nextpc (commit_nextpc),
    .commit_inst   (commit_inst),
    .commit_ready  (commit_ready),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_pc        (out_pc),
    .out_nextpc    (out_nextpc),
    .out_inst      (out_inst),
    .out_rd        (out_rd),
    .out_is_call   (out_is_call),
    .call_depth    (call_depth),
    .full          (full)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] npc,
                       input logic [31:0] inst);
    commit_valid  = v;
    commit_pc     = pc;
    commit_nextpc = npc;
    commit_inst   = inst;
  endtask

  task automatic apply_reset();
    drive(1'b0, 32'h0, 32'h0, 32'h0);
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    out_ready = 1'b1;
    apply_reset();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
    checks++;
    if (call_depth !== 8'd0) begin errors++; $display("FAIL reset_call_depth got %0d want 0", call_depth); end
    checks++;
    if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %0b want 0", full); end
    checks++;
    if (commit_ready !== 1'b1) begin errors++; $display("FAIL reset_commit_ready got %0b want 1", commit_ready); end
  endtask

  task automatic test_call();
    out_ready = 1'b1;
    drive(1'b1, 32'h8000_0000, 32'h8000_0010, I_CALL);
    checks++;
    if (commit_ready !== 1'b1) begin errors++; $display("FAIL call_ready got %0b want 1", commit_ready); end
    tick();
    drive(1'b0, 32'h0, 32'h0, 32'h0);
    checks++;
    if (out_valid !== 1'b1 || out_is_call !== 1'b1 || out_rd !== 6'd1) begin
      errors++;
      $display("FAIL call_rec got v=%0b call=%0b rd=%0d want v=1 call=1 rd=1", out_valid, out_is_call, out_rd);
    end
    checks++;
    if (out_pc !== 32'h8000_0000 || out_nextpc !== 32'h8000_0010 || out_inst !== I_CALL) begin
      errors++;
      $display("FAIL call_payload got pc=%h npc=%h inst=%h want 80000000 80000010 %h", out_pc, out_nextpc, out_inst, I_CALL);
    end
    checks++;
    if (call_depth !== 8'd1) begin errors++; $display("FAIL call_depth got %0d want 1", call_depth); end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL call_drain got %0b want 0", out_valid); end
  endtask

  task automatic test_return();
    out_ready = 1'b1;
    drive(1'b1, 32'h8000_0020, 32'h8000_0004, I_RET);
    tick();
    drive(1'b0, 32'h0, 32'h0, 32'h0);
    checks++;
    if (out_valid !== 1'b1 || out_is_call !== 1'b0 || out_rd !== 6'd0 || out_pc !== 32'h8000_0020) begin
      errors++;
      $display("FAIL ret_rec got v=%0b call=%0b rd=%0d pc=%h want v=1 call=0 rd=0 pc=80000020",
               out_valid, out_is_call, out_rd, out_pc);
    end
    checks++;
    if (call_depth !== 8'd0) begin errors++; $display("FAIL ret_depth got %0d want 0", call_depth); end
    tick();
    drive(1'b1, 32'h8000_0030, 32'h0000_0000, I_RET);
    tick();
    drive(1'b0, 32'h0, 32'h0, 32'h0);
    checks++;
    if (out_valid !== 1'b1 || out_is_call !== 1'b0 || out_pc !== 32'h8000_0030) begin
      errors++;
      $display("FAIL ret2_rec got v=%0b call=%0b pc=%h want v=1 call=0 pc=80000030", out_valid, out_is_call, out_pc);
    end
    checks++;
    if (call_depth !== 8'd0) begin errors++; $display("FAIL ret2_depth_sat got %0d want 0", call_depth); end
    tick();
  endtask

  task automatic test_untraced();
    logic [31:0] insts [3];
    logic        exp_v [3];
    insts[0] = I_J;    exp_v[0] = 1'b0;
    insts[1] = I_NOP;  exp_v[1] = 1'b0;
    insts[2] = I_JALR; exp_v[2] = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h8000_0100 + 32'(i * 4), 32'h8000_0200, insts[i]);
      checks++;
      if (commit_ready !== 1'b1) begin errors++; $display("FAIL untraced_ready[%0d] got %0b want 1", i, commit_ready); end
      tick();
      checks++;
      if (out_valid !== exp_v[i]) begin
        errors++;
        $display("FAIL untraced_valid[%0d] got %0b want %0b", i, out_valid, exp_v[i]);
      end
    end
    drive(1'b0, 32'h0, 32'h0, 32'h0);
    checks++;
    if (out_is_call !== 1'b1 || out_pc !== 32'h8000_0108) begin
      errors++;
      $display("FAIL jalr_rec got call=%0b pc=%h want call=1 pc=80000108", out_is_call, out_pc);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL untraced_drain got %0b want 0", out_valid); end
  endtask

  task automatic test_full();
    out_ready = 1'b1;
    apply_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h0000_1000 + 32'(i * 4), 32'h0000_2000, I_CALL);
      checks++;
      if (commit_ready !== 1'b1) begin errors++; $display("FAIL fill_ready[%0d] got %0b want 1", i, commit_ready); end
      tick();
    end
    checks++;
    if (full !== 1'b1) begin errors++; $display("FAIL full_set got %0b want 1", full); end
    drive(1'b1, 32'h0000_1010, 32'h0000_2000, I_CALL);
    checks++;
    if (commit_ready !== 1'b0) begin errors++; $display("FAIL full_stall got %0b want 0", commit_ready); end
    tick();
    checks++;
    if (full !== 1'b1 || call_depth !== 8'd4 || out_pc !== 32'h0000_1000) begin
      errors++;
      $display("FAIL stall_hold got full=%0b depth=%0d pc=%h want 1 4 00001000", full, call_depth, out_pc);
    end
    // Dequeue while full: the held call is still refused this cycle.
    out_ready = 1'b1;
    tick();
    checks++;
    if (full !== 1'b0 || out_pc !== 32'h0000_1004 || call_depth !== 8'd4) begin
      errors++;
      $display("FAIL full_deq got full=%0b pc=%h depth=%0d want 0 00001004 4", full, out_pc, call_depth);
    end
    checks++;
    if (commit_ready !== 1'b1) begin errors++; $display("FAIL unstall_ready got %0b want 1", commit_ready); end
    tick();
    drive(1'b0, 32'h0, 32'h0, 32'h0);
    checks++;
    if (call_depth !== 8'd5) begin errors++; $display("FAIL final_depth got %0d want 5", call_depth); end
    for (int i = 2; i < 5; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 32'h0000_1000 + 32'(i * 4)) begin
        errors++;
        $display("FAIL drain_order[%0d] got v=%0b pc=%h want v=1 pc=%h", i, out_valid, out_pc, 32'h0000_1000 + 32'(i * 4));
      end
      tick();
    end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL full_empty got %0b want 0", out_valid); end
  endtask

  task automatic test_reset_midop();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h0000_3000 + 32'(i * 4), 32'h0000_4000, I_CALL);
      tick();
    end
    drive(1'b0, 32'h0, 32'h0, 32'h0);
    checks++;
    if (out_valid !== 1'b1 || call_depth !== 8'd8) begin
      errors++;
      $display("FAIL prereset got v=%0b depth=%0d want 1 8", out_valid, call_depth);
    end
    out_ready = 1'b1;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    checks++;
    if (out_valid !== 1'b0 || call_depth !== 8'd0 || full !== 1'b0) begin
      errors++;
      $display("FAIL midreset got v=%0b depth=%0d full=%0b want 0 0 0", out_valid, call_depth, full);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL stale_rec[%0d] got %0b want 0", i, out_valid); end
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 32'h0000_5000 + 32'(i * 4), 32'h0000_6000, I_CALL);
      tick();
    end
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 32'h0000_5008 + 32'(i * 4), 32'h0000_6000, I_CALL);
      checks++;
      if (out_valid !== 1'b1 || full !== 1'b0 || out_pc !== 32'h0000_5000 + 32'(i * 4)) begin
        errors++;
        $display("FAIL b2b[%0d] got v=%0b full=%0b pc=%h want 1 0 %h", i, out_valid, full, out_pc,
                 32'h0000_5000 + 32'(i * 4));
      end
      tick();
    end
    drive(1'b0, 32'h0, 32'h0, 32'h0);
    for (int i = 10; i < 12; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 32'h0000_5000 + 32'(i * 4)) begin
        errors++;
        $display("FAIL b2b_tail[%0d] got v=%0b pc=%h want 1 %h", i, out_valid, out_pc, 32'h0000_5000 + 32'(i * 4));
      end
      tick();
    end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_empty got %0b want 0", out_valid); end
    checks++;
    if (call_depth !== 8'd12) begin errors++; $display("FAIL b2b_depth got %0d want 12", call_depth); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 32'h0);
    test_reset();
    test_call();
    test_return();
    test_untraced();
    test_full();
    test_reset_midop();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
